// File: rtl/dport_uart.sv
// Debug-port serializer: up to two bytes/clock into a FIFO, sent as 8N1 frames on tx.
// Two-cycle start latency from write to start bit; bytes that find no free slot are dropped and flagged.
module dport_uart #(
    parameter int CLK_DIV    = 868,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr1,
    input  logic [7:0]            data1,
    input  logic                  wr2,
    input  logic [7:0]            data2,
    input  logic                  done_in,
    output logic                  tx,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  drained
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int BW    = $clog2(CLK_DIV);
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [LW-1:0] DEPTH_V   = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_V     = LW'(1);
    localparam logic [LW-1:0] TWO_V     = LW'(2);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wptr_nx;
    logic [LW-1:0]         level_q, level_d, free_slots;
    logic                  overflow_q, overflow_d;
    logic                  done_seen_q, done_seen_d;
    logic                  drained_q, drained_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    state_t                state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  take1, take2, pop, bit_end;
    logic [7:0]            first_byte;

    assign pop     = (state_q == S_IDLE) && (level_q != '0);
    assign bit_end = (baud_q == BAUD_LAST);
    assign wptr_nx = wptr_q + DEPTH_LOG2'(1);

    // Free space is judged on the pre-pop level, so a same-cycle pop never makes room.
    always_comb begin
        free_slots  = DEPTH_V - level_q;
        take1       = wr1 && (free_slots >= ONE_V);
        take2       = wr2 && (free_slots >= (wr1 ? TWO_V : ONE_V));
        first_byte  = take1 ? data1 : data2;
        wptr_d      = wptr_q + DEPTH_LOG2'(take1) + DEPTH_LOG2'(take2);
        rptr_d      = rptr_q + DEPTH_LOG2'(pop);
        level_d     = level_q + LW'(take1) + LW'(take2) - LW'(pop);
        overflow_d  = overflow_q | (wr1 & ~take1) | (wr2 & ~take2);
        done_seen_d = done_seen_q | done_in;
        drained_d   = done_seen_q && (level_q == '0) && (state_q == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (take1 || take2) mem_q[wptr_q]  <= first_byte;
        if (take1 && take2) mem_q[wptr_nx] <= data2;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d = mem_q[rptr_q];
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // tx and busy are registered from the next state so they line up with it.
        tx_d   = 1'b1;
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            done_seen_q <= 1'b0;
            drained_q   <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            done_seen_q <= done_seen_d;
            drained_q   <= drained_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign drained  = drained_q;

endmodule

// File: tb/tb_dport_uart.sv
// Bench for dport_uart: expected bytes queued at write time, decoded frames checked by a tx monitor.
module tb_dport_uart;
    localparam int D  = 4;
    localparam int DL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr1, wr2, done_in;
    logic [7:0]  data1, data2;
    logic        tx, busy, overflow, drained;
    logic [DL:0] level;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [7:0]  exp_q[$];
    int          start_q[$];

    dport_uart #(.CLK_DIV(D), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .wr1(wr1), .data1(data1), .wr2(wr2), .data2(data2),
        .done_in(done_in), .tx(tx), .busy(busy), .level(level),
        .overflow(overflow), .drained(drained)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || level != 0) && n < 2000) begin
            step();
            n++;
        end
        chk({name, "_timeout"}, int'(n < 2000), 1);
    endtask

    // tx frame decoder; samples each bit in the middle of its CLK_DIV window
    logic       mon_act = 1'b0;
    logic       tx_prev = 1'b1;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = '0;
    logic [2:0] mon_idx;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            mon_act = 1'b0;
            tx_prev = 1'b1;
        end else begin
            if (!mon_act) begin
                if (tx_prev && !tx) begin
                    mon_act = 1'b1;
                    mon_cnt = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                mon_cnt++;
                if (mon_cnt == D / 2) begin
                    chk("start_bit", int'(tx), 0);
                end else if (mon_cnt >= D + D / 2 && mon_cnt < 9 * D && (mon_cnt - D - D / 2) % D == 0) begin
                    mon_idx = 3'((mon_cnt - D - D / 2) / D);
                    mon_byte[mon_idx] = tx;
                end else if (mon_cnt == 9 * D + D / 2) begin
                    chk("stop_bit", int'(tx), 1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL frame_byte: got unexpected byte 0x%02h, required no frame", mon_byte);
                    end else begin
                        chk("frame_byte", int'(mon_byte), int'(exp_q.pop_front()));
                    end
                    mon_act = 1'b0;
                end
            end
            tx_prev = tx;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bcnt;
        int k;
        rst = 1'b0; wr1 = 1'b0; wr2 = 1'b0; data1 = '0; data2 = '0; done_in = 1'b0;
        repeat (3) step();
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_drained", int'(drained), 0);
        rst = 1'b1;
        repeat (2) step();

        // single byte, latency and busy width
        exp_q.push_back(8'h41);
        wr1 = 1'b1; data1 = 8'h41;
        step();
        wr1 = 1'b0;
        chk("single_level", int'(level), 1);
        chk("single_tx_idle", int'(tx), 1);
        step();
        chk("single_tx_fall", int'(tx), 0);
        chk("single_busy", int'(busy), 1);
        bcnt = 1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (!busy) break;
            bcnt++;
        end
        chk("single_busy_len", bcnt, 10 * D);
        wait_drain("single");

        // dual write ordering and frame spacing
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        wr1 = 1'b1; data1 = 8'h12; wr2 = 1'b1; data2 = 8'h34;
        step();
        wr1 = 1'b0; wr2 = 1'b0;
        chk("dual_level", int'(level), 2);
        wait_drain("dual");
        chk("dual_gap", start_q[start_q.size() - 1] - start_q[start_q.size() - 2], 10 * D + 1);

        // three dual writes into a 4-deep FIFO: 0x06 dropped, 0x05 fits
        for (int b = 1; b <= 5; b++) exp_q.push_back(8'(b));
        wr1 = 1'b1; wr2 = 1'b1;
        data1 = 8'h01; data2 = 8'h02; step();
        chk("ovf_level0", int'(level), 2);
        data1 = 8'h03; data2 = 8'h04; step();
        chk("ovf_level1", int'(level), 3);
        chk("ovf_clear1", int'(overflow), 0);
        data1 = 8'h05; data2 = 8'h06; step();
        wr1 = 1'b0; wr2 = 1'b0;
        chk("ovf_level2", int'(level), 4);
        chk("ovf_set", int'(overflow), 1);
        wait_drain("ovf");
        chk("ovf_sticky", int'(overflow), 1);

        rst = 1'b0;
        #1;
        chk("rst_ovf_clear", int'(overflow), 0);
        exp_q.delete();
        step();
        rst = 1'b1;
        step();

        // fill to 4 while a frame runs, then push on the popping edge
        exp_q.push_back(8'hA0);
        wr1 = 1'b1; data1 = 8'hA0; step();
        for (int b = 1; b <= 4; b++) exp_q.push_back(8'hA0 + 8'(b));
        wr2 = 1'b1; data1 = 8'hA1; data2 = 8'hA2; step();
        chk("pdp_level_mid", int'(level), 2);
        data1 = 8'hA3; data2 = 8'hA4; step();
        wr1 = 1'b0; wr2 = 1'b0;
        chk("pdp_level_full", int'(level), 4);
        chk("pdp_no_ovf", int'(overflow), 0);
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            step();
        end
        chk("pdp_idle_reached", int'(busy), 0);
        wr1 = 1'b1; data1 = 8'hEE;
        step();
        wr1 = 1'b0;
        chk("pdp_level", int'(level), 3);
        chk("pdp_overflow", int'(overflow), 1);
        chk("pdp_busy", int'(busy), 1);

        // reset during DATA bit 3 of the 0xA1 frame
        repeat (16) step();
        chk("mid_tx_bit3", int'(tx), 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_tx", int'(tx), 1);
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_busy", int'(busy), 0);
        exp_q.delete();
        step();
        rst = 1'b1;
        step();
        exp_q.push_back(8'h5A);
        wr1 = 1'b1; data1 = 8'h5A; step();
        wr1 = 1'b0;
        step();
        chk("post_rst_tx_fall", int'(tx), 0);
        wait_drain("post_rst");

        // drained rises one cycle after the second frame's stop bit
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h3C);
        wr1 = 1'b1; data1 = 8'hC3; wr2 = 1'b1; data2 = 8'h3C;
        step();
        wr1 = 1'b0; wr2 = 1'b0;
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        chk("drain_early", int'(drained), 0);
        k = 1;
        while (!drained && k < 400) begin
            step();
            k++;
        end
        chk("drain_time", k, 2 * (10 * D + 1) + 1);
        repeat (5) step();
        chk("drain_hold", int'(drained), 1);
        chk("drain_frames_done", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
